draw_grid_items: RTL
====================

# draw_grid_items

Parametrised multi-object grid renderer for the VGA pixel pipeline. It overlays up to `N_ITEMS` coloured grid cells (apples, bonuses, obstacles) onto the incoming RGB stream, with per-item enable, colour and blink. Cell position is tracked with counters, not multipliers or dividers. It sits in the draw chain between the background/board stage and the snake-body stage and forwards the timing signals with matched latency.

## Interface
Parameters:
- `N_ITEMS`, 4: number of drawable items; 1..16.
- `COL_W`, 7: width of a column index.
- `ROW_W`, 6: width of a row index.
- `GRID_W`, 10: width of `grid_size`.
- `BLINK_FRAMES`, 16: frames per blink half-period; must be ≥ 1.

Ports:
- `pclk`, in, 1: pixel clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `hcount_in`, `vcount_in`, in, 11 each: pixel coordinates.
- `hsync_in`, `hblnk_in`, `vsync_in`, `vblnk_in`, in, 1 each: timing signals.
- `rgb_in`, in, 12: upstream colour.
- `grid_size`, in, `GRID_W`: cell edge length in pixels.
- `item_x`, in, `N_ITEMS*COL_W`: 1-based column per item; item i occupies slice i.
- `item_y`, in, `N_ITEMS*ROW_W`: 1-based row per item.
- `item_rgb`, in, `N_ITEMS*12`: colour per item.
- `item_en`, in, `N_ITEMS`: item drawn when 1.
- `item_blink`, in, `N_ITEMS`: item follows the blink phase when 1.
- `hcount_out`, `vcount_out`, out, 11 each: delayed copies of the inputs.
- `hsync_out`, `hblnk_out`, `vsync_out`, `vblnk_out`, out, 1 each: delayed copies of the inputs.
- `rgb_out`, out, 12: composited colour.

## Operation
- Cell model: a pixel lies in column `hcount/gs + 1` and row `vcount/gs + 1`, where `gs` is the latched grid size. Index 0 is never produced, so an item with x=0 or y=0 is never drawn.
- Column tracker, evaluated every cycle:
  - If `hcount_in == 0`, set `col = 1` and `pcnt = 0`.
  - Else if `pcnt == gs-1`, set `pcnt = 0` and increment `col`, saturating at all-ones.
  - Else increment `pcnt`.
  - The design relies on `hcount_in` stepping by 1 per cycle.
- Row tracker, updated only when `hcount_in == 0`:
  - If `vcount_in == 0`, set `row = 1` and `rcnt = 0`.
  - Else apply the same wrap/saturate rule to `rcnt` and `row`.
- Grid size latch: `gs` loads `grid_size` only in the cycle where `hcount_in == 0 && vcount_in == 0`. A mid-frame change therefore takes effect at the next frame. If `gs == 0`, nothing is drawn and `rgb_out` follows `rgb_in`.
- Item hit for item i requires all of the following:
  - `item_en[i]`;
  - `x_i == col` and `y_i == row`;
  - `x_i != 0` and `y_i != 0`;
  - `!item_blink[i] || phase`.
- Priority: the lowest-index hit wins, so `rgb_out` equals that item's `item_rgb`. With no hit, `rgb_out = rgb_in`.
- Blink counter:
  - `fcnt` increments on each rising edge of `vsync_in`, detected with a registered previous value.
  - When `fcnt == BLINK_FRAMES-1`, it wraps to 0 and `phase` toggles.
- Item inputs are sampled in stage 1. Changing them mid-frame is legal and affects pixels from that cycle onward. There is no tearing protection.

## Timing
- Latency is 2 `pclk` cycles from any input to the matching outputs. All timing outputs are delayed identically to `rgb_out`.
- Stage 1 registers the timing signals, `rgb_in`, `col`, `row` and the sampled item vectors.
- Stage 2 registers the priority-mux result and the timing signals to the outputs.
- Reset values: all outputs 0; `col = 1`, `row = 1`, `pcnt = 0`, `rcnt = 0`, `gs = 0` (nothing drawn until the first frame start), `fcnt = 0`, `phase = 1`, previous-vsync register 0.
- Reset mid-frame: the outputs clear immediately. Drawing resumes at the first `hcount = 0, vcount = 0` after reset is released.
- A vsync edge coinciding with a frame start updates `fcnt`/`phase` and `gs` in the same cycle. Both updates are independent.

## Structure
- Shared package `snake_pkg`: `RGB_W = 12`, `HV_W = 11`, and the default `COL_W`, `ROW_W`, `GRID_W` values.
- One sub-module, `grid_cell_tracker`, owns the `gs` latch and the column/row counters and outputs `col`, `row` and `gs_zero`. It is reusable by the snake-body and head renderers.
- The blink logic and priority mux stay in the top module.

## Test plan
- gs=16, item0 at (3,2), en=1, colour 0xF00 → `rgb_out = 0xF00` exactly for h 32..47, v 16..31, appearing 2 cycles after the pixel; `rgb_in` passes through elsewhere.
- Items 0 and 2 both at (5,5) with colours 0x0F0 and 0x00F → 0x0F0 is drawn. With `item_en[0] = 0` → 0x00F is drawn.
- item1 at (0,4) or (4,0), enabled → never drawn. item at col 127 with gs=8 → column saturation: drawn for every h ≥ 1008.
- `grid_size` changes from 16 to 20 mid-frame → the current frame keeps 16-pixel cells; the next frame uses 20. `grid_size = 0` → `rgb_out == rgb_in` on every pixel.
- `BLINK_FRAMES = 2`, `item_blink[0] = 1` → item visible in frames 0–1, hidden in frames 2–3, visible in frames 4–5. A non-blinking item is always visible.
- Assert `rst` at pixel (300,200) mid-frame → all outputs 0 on the next edge. After release, nothing is drawn until the next frame start, then drawing is correct; `phase` restarts at 1.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake VGA draw chain.
//   RGB_W / HV_W     : colour and pixel-coordinate widths used by every stage
//   *_DEF            : default grid geometry widths for the grid renderers
//   vga_timing_t     : timing bundle carried alongside the colour in each stage
package snake_pkg;

    localparam int RGB_W      = 12;
    localparam int HV_W       = 11;
    localparam int COL_W_DEF  = 7;
    localparam int ROW_W_DEF  = 6;
    localparam int GRID_W_DEF = 10;

    typedef struct packed {
        logic [HV_W-1:0] hcount;
        logic [HV_W-1:0] vcount;
        logic            hsync;
        logic            hblnk;
        logic            vsync;
        logic            vblnk;
    } vga_timing_t;

endpackage

// File: rtl/draw_grid_items_if.sv
// Pixel-stream and item-descriptor bus for draw_grid_items.
//   *_in       : upstream timing + colour, grid size, per-item descriptors
//   *_out      : timing + composited colour, delayed by the renderer
//   master     : drives the inputs (upstream stage / bench)
//   slave      : the renderer
interface draw_grid_items_if #(
    parameter int N_ITEMS = 4,
    parameter int COL_W   = snake_pkg::COL_W_DEF,
    parameter int ROW_W   = snake_pkg::ROW_W_DEF,
    parameter int GRID_W  = snake_pkg::GRID_W_DEF
) ();
    import snake_pkg::*;

    logic [HV_W-1:0]          hcount_in;
    logic [HV_W-1:0]          vcount_in;
    logic                     hsync_in;
    logic                     hblnk_in;
    logic                     vsync_in;
    logic                     vblnk_in;
    logic [RGB_W-1:0]         rgb_in;
    logic [GRID_W-1:0]        grid_size;
    logic [N_ITEMS*COL_W-1:0] item_x;
    logic [N_ITEMS*ROW_W-1:0] item_y;
    logic [N_ITEMS*RGB_W-1:0] item_rgb;
    logic [N_ITEMS-1:0]       item_en;
    logic [N_ITEMS-1:0]       item_blink;

    logic [HV_W-1:0]          hcount_out;
    logic [HV_W-1:0]          vcount_out;
    logic                     hsync_out;
    logic                     hblnk_out;
    logic                     vsync_out;
    logic                     vblnk_out;
    logic [RGB_W-1:0]         rgb_out;

    modport master (
        output hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in,
               grid_size, item_x, item_y, item_rgb, item_en, item_blink,
        input  hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out
    );

    modport slave (
        input  hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in, rgb_in,
               grid_size, item_x, item_y, item_rgb, item_en, item_blink,
        output hcount_out, vcount_out, hsync_out, hblnk_out, vsync_out, vblnk_out, rgb_out
    );

endinterface

// File: rtl/grid_cell_tracker.sv
// Tracks which grid cell the current pixel falls in, using counters instead
// of a divider. Outputs are registered, so they line up with any signal the
// caller registers once from the same input cycle.
//   pclk, rst       : pixel clock, async active-high reset
//   hcount_i/vcount_i : pixel coordinates (hcount must step by 1 per cycle)
//   grid_size_i     : cell edge length, latched only at pixel (0,0)
//   col_o / row_o   : 1-based cell column / row, saturating at all-ones
//   gs_zero_o       : latched grid size is 0 (caller should draw nothing)
module grid_cell_tracker #(
    parameter int COL_W  = snake_pkg::COL_W_DEF,
    parameter int ROW_W  = snake_pkg::ROW_W_DEF,
    parameter int GRID_W = snake_pkg::GRID_W_DEF,
    parameter int HV_W   = snake_pkg::HV_W
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [HV_W-1:0]   hcount_i,
    input  logic [HV_W-1:0]   vcount_i,
    input  logic [GRID_W-1:0] grid_size_i,
    output logic [COL_W-1:0]  col_o,
    output logic [ROW_W-1:0]  row_o,
    output logic              gs_zero_o
);

    logic [GRID_W-1:0] gs_q, gs_d;
    logic [GRID_W-1:0] pcnt_q, pcnt_d;
    logic [GRID_W-1:0] rcnt_q, rcnt_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [GRID_W-1:0] gs_last;
    logic              line_start;

    assign line_start = (hcount_i == '0);
    // Wrap compare uses the size of the current frame; col/row are forced
    // to 1 at (0,0), so the new size is in place before it is first needed.
    assign gs_last    = gs_q - GRID_W'(1);

    always_comb begin
        gs_d   = gs_q;
        pcnt_d = pcnt_q;
        col_d  = col_q;
        rcnt_d = rcnt_q;
        row_d  = row_q;

        if (line_start && vcount_i == '0)
            gs_d = grid_size_i;

        if (line_start) begin
            col_d  = COL_W'(1);
            pcnt_d = '0;
        end else if (pcnt_q == gs_last) begin
            pcnt_d = '0;
            if (col_q != '1)
                col_d = col_q + COL_W'(1);
        end else begin
            pcnt_d = pcnt_q + GRID_W'(1);
        end

        if (line_start) begin
            if (vcount_i == '0) begin
                row_d  = ROW_W'(1);
                rcnt_d = '0;
            end else if (rcnt_q == gs_last) begin
                rcnt_d = '0;
                if (row_q != '1)
                    row_d = row_q + ROW_W'(1);
            end else begin
                rcnt_d = rcnt_q + GRID_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            gs_q   <= '0;
            pcnt_q <= '0;
            rcnt_q <= '0;
            col_q  <= COL_W'(1);
            row_q  <= ROW_W'(1);
        end else begin
            gs_q   <= gs_d;
            pcnt_q <= pcnt_d;
            rcnt_q <= rcnt_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

    assign col_o     = col_q;
    assign row_o     = row_q;
    assign gs_zero_o = (gs_q == '0);

endmodule

// File: rtl/draw_grid_items.sv
// Overlays up to N_ITEMS coloured grid cells on the VGA stream, with
// per-item enable, colour and blink; lowest index wins on overlap.
// Two-cycle latency: stage 1 registers inputs (cell position comes from
// grid_cell_tracker on the same edge), stage 2 registers the mux result.
//   pclk, rst : pixel clock, async active-high reset
//   bus       : draw_grid_items_if slave (pixel stream in/out + items)
module draw_grid_items #(
    parameter int N_ITEMS      = 4,
    parameter int COL_W        = snake_pkg::COL_W_DEF,
    parameter int ROW_W        = snake_pkg::ROW_W_DEF,
    parameter int GRID_W       = snake_pkg::GRID_W_DEF,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              pclk,
    input  logic              rst,
    draw_grid_items_if.slave  bus
);
    import snake_pkg::*;

    localparam int             FC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    vga_timing_t              tim_in;
    vga_timing_t [2:1]        tim_pipe_q;
    logic [RGB_W-1:0]         rgb_s1_q;
    logic [N_ITEMS*COL_W-1:0] x_s1_q;
    logic [N_ITEMS*ROW_W-1:0] y_s1_q;
    logic [N_ITEMS*RGB_W-1:0] c_s1_q;
    logic [N_ITEMS-1:0]       en_s1_q;
    logic [N_ITEMS-1:0]       bl_s1_q;
    logic [RGB_W-1:0]         rgb_out_q, rgb_d;

    logic [COL_W-1:0]         col;
    logic [ROW_W-1:0]         row;
    logic                     gs_zero;

    logic                     vs_prev_q;
    logic                     vs_rise;
    logic [FC_W-1:0]          fcnt_q, fcnt_d;
    logic                     phase_q, phase_d;

    logic [N_ITEMS-1:0]       hit;

    assign tim_in = {bus.hcount_in, bus.vcount_in,
                     bus.hsync_in, bus.hblnk_in, bus.vsync_in, bus.vblnk_in};

    grid_cell_tracker #(
        .COL_W  (COL_W),
        .ROW_W  (ROW_W),
        .GRID_W (GRID_W),
        .HV_W   (HV_W)
    ) u_tracker (
        .pclk        (pclk),
        .rst         (rst),
        .hcount_i    (bus.hcount_in),
        .vcount_i    (bus.vcount_in),
        .grid_size_i (bus.grid_size),
        .col_o       (col),
        .row_o       (row),
        .gs_zero_o   (gs_zero)
    );

    // Blink phase advances on vsync rising edges, toggling every
    // BLINK_FRAMES frames.
    assign vs_rise = bus.vsync_in & ~vs_prev_q;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (vs_rise) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FC_W'(1);
            end
        end
    end

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_hit
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
        assign x      = x_s1_q[i*COL_W +: COL_W];
        assign y      = y_s1_q[i*ROW_W +: ROW_W];
        assign hit[i] = en_s1_q[i] && !gs_zero
                     && (x == col) && (y == row)
                     && (x != '0) && (y != '0)
                     && (!bl_s1_q[i] || phase_q);
    end

    // Walk from the top index down so the lowest-index hit is applied last.
    always_comb begin
        rgb_d = rgb_s1_q;
        for (int i = N_ITEMS - 1; i >= 0; i--)
            if (hit[i])
                rgb_d = c_s1_q[i*RGB_W +: RGB_W];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tim_pipe_q <= '0;
            rgb_s1_q   <= '0;
            x_s1_q     <= '0;
            y_s1_q     <= '0;
            c_s1_q     <= '0;
            en_s1_q    <= '0;
            bl_s1_q    <= '0;
            rgb_out_q  <= '0;
            vs_prev_q  <= 1'b0;
            fcnt_q     <= '0;
            phase_q    <= 1'b1;
        end else begin
            tim_pipe_q[1] <= tim_in;
            tim_pipe_q[2] <= tim_pipe_q[1];
            rgb_s1_q      <= bus.rgb_in;
            x_s1_q        <= bus.item_x;
            y_s1_q        <= bus.item_y;
            c_s1_q        <= bus.item_rgb;
            en_s1_q       <= bus.item_en;
            bl_s1_q       <= bus.item_blink;
            rgb_out_q     <= rgb_d;
            vs_prev_q     <= bus.vsync_in;
            fcnt_q        <= fcnt_d;
            phase_q       <= phase_d;
        end
    end

    assign bus.hcount_out = tim_pipe_q[2].hcount;
    assign bus.vcount_out = tim_pipe_q[2].vcount;
    assign bus.hsync_out  = tim_pipe_q[2].hsync;
    assign bus.hblnk_out  = tim_pipe_q[2].hblnk;
    assign bus.vsync_out  = tim_pipe_q[2].vsync;
    assign bus.vblnk_out  = tim_pipe_q[2].vblnk;
    assign bus.rgb_out    = rgb_out_q;

endmodule
